// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared types and constants for the SDRAM controller slice.
//   sdram_bus_t  : packed SDRAM command bus {cmd[3:0], ba[1:0], addr[12:0]}
//   arb_state_t  : arbiter FSM state encoding
//   CMD_NOP      : {cs_n,ras_n,cas_n,we_n} no-operation command
//   BUS_NOP      : full bus value driven while nobody owns the SDRAM
// ---------------------------------------------------------------------------
package sdram_pkg;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } sdram_bus_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  localparam sdram_bus_t BUS_NOP = '{cmd: CMD_NOP, ba: 2'b00, addr: 13'd0};

endpackage

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
// Arbitrates SDRAM ownership between the power-up init sequencer, the
// auto-refresh engine, the write engine and the read engine, and muxes the
// owner's command bus onto the SDRAM pins with no added latency.
//
// Ports
//   sys_clk, sys_rst           : clock (rising edge), async active-high reset
//   init_end, init_bus         : init sequencer done level / its command bus
//   aref_req/end/bus, aref_en  : refresh request, done pulse, bus, grant
//   wr_req/end/bus, wr_en      : write request, done pulse, bus, grant
//   wr_sdram_en, wr_sdram_data : write data drive enable / write data
//   rd_req/end/bus, rd_en      : read request, done pulse, bus, grant
//   sdram_cke/cmd/ba/addr      : SDRAM control pins
//   sdram_dq_o, sdram_dq_oe    : data pad output value and output enable
//
// Configuration
//   SDRAM_ARBIT_RR_EN : when defined, write and read alternate whenever both
//                       are pending (write goes first after reset). When
//                       undefined, write always beats read and no flag
//                       register exists. Refresh always has top priority.
// ---------------------------------------------------------------------------
module sdram_arbit
  import sdram_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,

  input  logic        init_end,
  input  sdram_bus_t  init_bus,

  input  logic        aref_req,
  input  logic        aref_end,
  input  sdram_bus_t  aref_bus,
  output logic        aref_en,

  input  logic        wr_req,
  input  logic        wr_end,
  input  sdram_bus_t  wr_bus,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  output logic        wr_en,

  input  logic        rd_req,
  input  logic        rd_end,
  input  sdram_bus_t  rd_bus,
  output logic        rd_en,

  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe
);

  arb_state_t r_state;
  sdram_bus_t w_bus;
  logic       w_pickRead;
  logic       w_pickWrite;

`ifdef SDRAM_ARBIT_RR_EN
  // High when the most recent wr/rd grant went to the write engine.
  logic       r_lastWr;

  // Read wins a wr/rd tie only if write was served last.
  assign w_pickRead  = rd_req && (!wr_req || r_lastWr);
`else
  // Fixed priority: read is only chosen when no write is waiting.
  assign w_pickRead  = rd_req && !wr_req;
`endif

  assign w_pickWrite = wr_req && !w_pickRead;

  // Ownership FSM. Requests are only looked at in ARBIT, and each busy
  // state only listens to its own client's end pulse, so a stray end from
  // another client can never cut a burst short. Every grant returns through
  // ARBIT, which guarantees at least one NOP cycle between owners.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_INIT;
`ifdef SDRAM_ARBIT_RR_EN
      r_lastWr <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_INIT: begin
          if (init_end) r_state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          if (aref_req) begin
            r_state <= ST_AREF;
          end else if (w_pickWrite) begin
            r_state <= ST_WRITE;
`ifdef SDRAM_ARBIT_RR_EN
            r_lastWr <= 1'b1;
`endif
          end else if (w_pickRead) begin
            r_state <= ST_READ;
`ifdef SDRAM_ARBIT_RR_EN
            r_lastWr <= 1'b0;
`endif
          end
        end
        ST_AREF: begin
          if (aref_end) r_state <= ST_ARBIT;
        end
        ST_WRITE: begin
          if (wr_end) r_state <= ST_ARBIT;
        end
        ST_READ: begin
          if (rd_end) r_state <= ST_ARBIT;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Grants are decoded straight from the state so a client sees its grant
  // in the same cycle the arbiter enters its state, and loses it as soon
  // as reset forces INIT.
  assign aref_en = (r_state == ST_AREF);
  assign wr_en   = (r_state == ST_WRITE);
  assign rd_en   = (r_state == ST_READ);

  // Command bus mux: the owner's bus passes through combinationally so the
  // client engines keep full control of SDRAM command timing.
  always_comb begin
    w_bus = BUS_NOP;
    case (r_state)
      ST_INIT:  w_bus = init_bus;
      ST_ARBIT: w_bus = BUS_NOP;
      ST_AREF:  w_bus = aref_bus;
      ST_WRITE: w_bus = wr_bus;
      ST_READ:  w_bus = rd_bus;
      default:  w_bus = BUS_NOP;
    endcase
  end

  assign sdram_cmd  = w_bus.cmd;
  assign sdram_ba   = w_bus.ba;
  assign sdram_addr = w_bus.addr;
  assign sdram_cke  = 1'b1;

  // Data is always presented; only the write owner may turn the pad on.
  assign sdram_dq_o  = wr_sdram_data;
  assign sdram_dq_oe = (r_state == ST_WRITE) && wr_sdram_en;

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit
// Self-checking bench for sdram_arbit. Directed scenarios use constant
// expectations; the random scenario compares against an owner-tracking
// reference model. Set SDRAM_ARBIT_RR_EN to check the round-robin build.
// ---------------------------------------------------------------------------
module tb_sdram_arbit;

`ifdef SDRAM_ARBIT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [18:0] NOP_BUS  = {4'b0111, 2'b00, 13'd0};
  localparam logic [18:0] PRE_BUS  = {4'b0010, 2'b00, 13'h0400};
  localparam logic [18:0] AREF_BUS = {4'b0001, 2'b11, 13'h0011};
  localparam logic [18:0] WR_BUS   = {4'b0100, 2'b01, 13'h0123};
  localparam logic [18:0] RD_BUS   = {4'b0101, 2'b10, 13'h0456};

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic [18:0] init_bus;
  logic        aref_req, aref_end, aref_en;
  logic [18:0] aref_bus;
  logic        wr_req, wr_end, wr_en, wr_sdram_en;
  logic [18:0] wr_bus;
  logic [15:0] wr_sdram_data;
  logic        rd_req, rd_end, rd_en;
  logic [18:0] rd_bus;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe;

  int total = 0;
  int bad   = 0;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .init_end(init_end), .init_bus(init_bus),
    .aref_req(aref_req), .aref_end(aref_end), .aref_bus(aref_bus), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_bus(wr_bus),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_bus(rd_bus), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sys_clk = ~sys_clk;

  wire [18:0] pinBus = {sdram_cmd, sdram_ba, sdram_addr};
  wire [2:0]  grants = {aref_en, wr_en, rd_en};

  // Reference model: who owns the SDRAM. 0=init, 1=idle, 2=refresh,
  // 3=write, 4=read. lastWasWrite remembers the last wr/rd winner.
  int mOwner;
  bit mLastWasWrite;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mOwner        <= 0;
      mLastWasWrite <= 1'b0;
    end else begin
      case (mOwner)
        0: if (init_end) mOwner <= 1;
        1: begin
          if (aref_req) mOwner <= 2;
          else if (wr_req && rd_req) begin
            if (RR && mLastWasWrite) begin mOwner <= 4; mLastWasWrite <= 1'b0; end
            else begin mOwner <= 3; mLastWasWrite <= 1'b1; end
          end
          else if (wr_req) begin mOwner <= 3; mLastWasWrite <= 1'b1; end
          else if (rd_req) begin mOwner <= 4; mLastWasWrite <= 1'b0; end
        end
        2: if (aref_end) mOwner <= 1;
        3: if (wr_end) mOwner <= 1;
        4: if (rd_end) mOwner <= 1;
        default: mOwner <= 0;
      endcase
    end
  end

  task automatic cyc();
    @(negedge sys_clk);
  endtask

  task automatic clearInputs();
    init_end = 1'b0; aref_req = 1'b0; aref_end = 1'b0;
    wr_req = 1'b0; wr_end = 1'b0; wr_sdram_en = 1'b0; wr_sdram_data = 16'h0;
    rd_req = 1'b0; rd_end = 1'b0;
    init_bus = PRE_BUS; aref_bus = AREF_BUS; wr_bus = WR_BUS; rd_bus = RD_BUS;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    clearInputs();
    #1;
    total++;
    if (grants !== 3'b000 || sdram_dq_oe !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_grants: got grants=%b oe=%b want 000/0", grants, sdram_dq_oe);
    end
    total++;
    if (pinBus !== PRE_BUS || sdram_cke !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_bus: got bus=%h cke=%b want %h/1", pinBus, sdram_cke, PRE_BUS);
    end
    cyc();
    cyc();
    sys_rst = 1'b0;
  endtask

  // Init holds for 20 cycles even with a write pending, then ARBIT next edge.
  task automatic test_init();
    init_end = 1'b0;
    wr_req   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      init_bus = (i % 2 == 0) ? PRE_BUS : {4'b0010, 2'b00, 13'(i)};
      #1;
      total++;
      if (pinBus !== init_bus || grants !== 3'b000) begin
        bad++; $display("[TB] FAIL init_hold[%0d]: got bus=%h grants=%b want %h/000", i, pinBus, grants, init_bus);
      end
      cyc();
    end
    init_end = 1'b1;
    cyc();
    wr_req = 1'b0;
    #1;
    total++;
    if (pinBus !== NOP_BUS || grants !== 3'b000) begin
      bad++; $display("[TB] FAIL init_to_arbit: got bus=%h grants=%b want %h/000", pinBus, grants, NOP_BUS);
    end
    cyc();
  endtask

  task automatic test_priority();
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    #1;
    total++;
    if (grants !== 3'b000) begin
      bad++; $display("[TB] FAIL prio_no_comb_grant: got grants=%b want 000", grants);
    end
    cyc(); #1;
    total++;
    if (grants !== 3'b100 || pinBus !== AREF_BUS) begin
      bad++; $display("[TB] FAIL prio_aref: got grants=%b bus=%h want 100/%h", grants, pinBus, AREF_BUS);
    end
    aref_req = 1'b0; aref_end = 1'b1;
    cyc(); aref_end = 1'b0; #1;
    total++;
    if (grants !== 3'b000 || pinBus !== NOP_BUS) begin
      bad++; $display("[TB] FAIL prio_gap1: got grants=%b bus=%h want 000/%h", grants, pinBus, NOP_BUS);
    end
    cyc(); #1;
    total++;
    if (grants !== 3'b010 || pinBus !== WR_BUS) begin
      bad++; $display("[TB] FAIL prio_write: got grants=%b bus=%h want 010/%h", grants, pinBus, WR_BUS);
    end
    wr_req = 1'b0; wr_end = 1'b1;
    cyc(); wr_end = 1'b0; #1;
    total++;
    if (grants !== 3'b000) begin
      bad++; $display("[TB] FAIL prio_gap2: got grants=%b want 000", grants);
    end
    cyc(); #1;
    total++;
    if (grants !== 3'b001 || pinBus !== RD_BUS) begin
      bad++; $display("[TB] FAIL prio_read: got grants=%b bus=%h want 001/%h", grants, pinBus, RD_BUS);
    end
    rd_req = 1'b0; rd_end = 1'b1;
    cyc(); rd_end = 1'b0;
    cyc();
  endtask

  // Refresh arriving mid-write waits; foreign end pulses are ignored.
  task automatic test_aref_mid_write();
    wr_req = 1'b1;
    cyc(); wr_req = 1'b0; aref_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_end   = (i == 1);
      aref_end = (i == 2);
      #1;
      total++;
      if (grants !== 3'b010 || pinBus !== WR_BUS) begin
        bad++; $display("[TB] FAIL midwr_hold[%0d]: got grants=%b bus=%h want 010/%h", i, grants, pinBus, WR_BUS);
      end
      cyc();
    end
    rd_end = 1'b0; aref_end = 1'b0; wr_end = 1'b1;
    cyc(); wr_end = 1'b0; #1;
    total++;
    if (grants !== 3'b000 || pinBus !== NOP_BUS) begin
      bad++; $display("[TB] FAIL midwr_gap: got grants=%b bus=%h want 000/%h", grants, pinBus, NOP_BUS);
    end
    cyc(); #1;
    total++;
    if (grants !== 3'b100) begin
      bad++; $display("[TB] FAIL midwr_aref: got grants=%b want 100", grants);
    end
    aref_req = 1'b0; aref_end = 1'b1;
    cyc(); aref_end = 1'b0;
    cyc();
  endtask

  task automatic test_dq();
    wr_req = 1'b1; wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
    cyc(); #1;
    total++;
    if (wr_en !== 1'b1 || sdram_dq_o !== 16'hA5A5 || sdram_dq_oe !== 1'b1) begin
      bad++; $display("[TB] FAIL dq_write: got en=%b dq=%h oe=%b want 1/a5a5/1", wr_en, sdram_dq_o, sdram_dq_oe);
    end
    wr_sdram_en = 1'b0; #1;
    total++;
    if (sdram_dq_oe !== 1'b0) begin
      bad++; $display("[TB] FAIL dq_write_off: got oe=%b want 0", sdram_dq_oe);
    end
    wr_sdram_en = 1'b1; wr_req = 1'b0; wr_end = 1'b1; rd_req = 1'b1;
    cyc(); wr_end = 1'b0;
    cyc(); #1;
    total++;
    if (rd_en !== 1'b1 || sdram_dq_oe !== 1'b0 || sdram_dq_o !== 16'hA5A5) begin
      bad++; $display("[TB] FAIL dq_read: got en=%b dq=%h oe=%b want 1/a5a5/0", rd_en, sdram_dq_o, sdram_dq_oe);
    end
    rd_req = 1'b0; rd_end = 1'b1; wr_sdram_en = 1'b0;
    cyc(); rd_end = 1'b0;
    cyc();
  endtask

  // wr and rd held together: alternate in round-robin build, write-only otherwise.
  task automatic test_back_to_back();
    bit gotRead;
    bit seen;
    bit expRead;
    sys_rst = 1'b1; #1; sys_rst = 1'b0;
    init_end = 1'b1;
    cyc();
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0; gotRead = 1'b0;
      for (int w = 0; w < 6 && !seen; w++) begin
        cyc(); #1;
        if (wr_en || rd_en) begin seen = 1'b1; gotRead = rd_en; end
      end
      expRead = RR && (g % 2 == 1);
      total++;
      if (!seen || gotRead !== expRead) begin
        bad++; $display("[TB] FAIL b2b_grant[%0d]: seen=%b read=%b want seen=1 read=%b", g, seen, gotRead, expRead);
      end
      if (gotRead) rd_end = 1'b1; else wr_end = 1'b1;
      cyc(); rd_end = 1'b0; wr_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; wr_sdram_en = 1'b1;
    cyc(); cyc(); #1;
    total++;
    if (rd_en !== 1'b1) begin
      bad++; $display("[TB] FAIL rstrd_pre: got rd_en=%b want 1", rd_en);
    end
    #1; sys_rst = 1'b1; #1;
    total++;
    if (grants !== 3'b000 || sdram_dq_oe !== 1'b0 || pinBus !== init_bus) begin
      bad++; $display("[TB] FAIL rstrd_async: got grants=%b oe=%b bus=%h want 000/0/%h", grants, sdram_dq_oe, pinBus, init_bus);
    end
    cyc(); sys_rst = 1'b0; init_end = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      total++;
      if (grants !== 3'b000 || pinBus !== init_bus) begin
        bad++; $display("[TB] FAIL rstrd_reinit[%0d]: got grants=%b bus=%h want 000/%h", i, grants, pinBus, init_bus);
      end
    end
    init_end = 1'b1;
    cyc(); #1;
    total++;
    if (grants !== 3'b000 || pinBus !== NOP_BUS) begin
      bad++; $display("[TB] FAIL rstrd_arbit: got grants=%b bus=%h want 000/%h", grants, pinBus, NOP_BUS);
    end
    cyc(); #1;
    total++;
    if (rd_en !== 1'b1) begin
      bad++; $display("[TB] FAIL rstrd_regrant: got rd_en=%b want 1", rd_en);
    end
    rd_req = 1'b0; rd_end = 1'b1; wr_sdram_en = 1'b0;
    cyc(); rd_end = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    logic [18:0] expBus;
    logic [3:0]  expCtl;
    for (int i = 0; i < 600; i++) begin
      init_end      = ($urandom_range(0, 3) != 0);
      aref_req      = ($urandom_range(0, 5) == 0);
      wr_req        = ($urandom_range(0, 2) == 0);
      rd_req        = ($urandom_range(0, 2) == 0);
      aref_end      = ($urandom_range(0, 3) == 0);
      wr_end        = ($urandom_range(0, 3) == 0);
      rd_end        = ($urandom_range(0, 3) == 0);
      wr_sdram_en   = $urandom_range(0, 1);
      wr_sdram_data = 16'($urandom);
      init_bus      = 19'($urandom);
      aref_bus      = 19'($urandom);
      wr_bus        = 19'($urandom);
      rd_bus        = 19'($urandom);
      sys_rst       = ($urandom_range(0, 79) == 0);
      #1;
      case (mOwner)
        0: expBus = init_bus;
        2: expBus = aref_bus;
        3: expBus = wr_bus;
        4: expBus = rd_bus;
        default: expBus = NOP_BUS;
      endcase
      expCtl = {mOwner == 2, mOwner == 3, mOwner == 4, (mOwner == 3) && wr_sdram_en};
      total++;
      if ({grants, sdram_dq_oe} !== expCtl) begin
        bad++; $display("[TB] FAIL rand_ctl[%0d]: got grants/oe=%b want %b", i, {grants, sdram_dq_oe}, expCtl);
      end
      total++;
      if (pinBus !== expBus || sdram_dq_o !== wr_sdram_data || sdram_cke !== 1'b1) begin
        bad++; $display("[TB] FAIL rand_bus[%0d]: got bus=%h dq=%h cke=%b want %h/%h/1", i, pinBus, sdram_dq_o, sdram_cke, expBus, wr_sdram_data);
      end
      cyc();
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_priority();
    test_aref_mid_write();
    test_dq();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
